// File: rtl/riscv_test_monitor.sv
// Checkpoint monitor for a RISC-V core under test: compares OUTPUT_PORT against a
// loaded table of (retired-count, answer) pairs and reports PASS/FAIL/TIMEOUT.
module riscv_test_monitor #(
   parameter int unsigned NUM_TEST     = 17,
   parameter int unsigned IDX_W        = 5,
   parameter int unsigned DW           = 32,
   parameter int unsigned TIMEOUT      = 1000000,
   parameter int unsigned STOP_ON_FAIL = 1
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             LD_EN,
   input  logic [IDX_W-1:0] LD_IDX,
   input  logic [DW-1:0]    LD_NUM,
   input  logic [DW-1:0]    LD_ANS,
   input  logic             START,
   input  logic [DW-1:0]    NUM_INST,
   input  logic [DW-1:0]    OUTPUT_PORT,
   input  logic             HALT,
   output logic [2:0]       STATUS,
   output logic [IDX_W-1:0] FAIL_IDX,
   output logic [DW-1:0]    FAIL_GOT,
   output logic [IDX_W:0]   PASS_CNT,
   output logic [DW-1:0]    CYCLE_CNT
);
   localparam int unsigned PW = IDX_W + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    pass_q, pass_d;
   logic [DW-1:0]    cyc_q, cyc_d;
   logic [DW-1:0]    got_q, got_d;
   logic [IDX_W-1:0] fidx_q, fidx_d;
   logic             err_q, err_d;

   logic [DW-1:0] tab_num [NUM_TEST];
   logic [DW-1:0] tab_ans [NUM_TEST];
   logic [DW-1:0] cur_num, cur_ans;
   logic          in_range, hit, skip, mism, good;

   // Checkpoint table: written only while idle, never reset
   always_ff @(posedge CLK) begin
      if (LD_EN && state_q == S_IDLE) begin
         for (int unsigned i = 0; i < NUM_TEST; i++) begin
            if (LD_IDX == IDX_W'(i)) begin
               tab_num[i] <= LD_NUM;
               tab_ans[i] <= LD_ANS;
            end
         end
      end
   end

   // Current checkpoint select and compare
   always_comb begin
      cur_num = '0;
      cur_ans = '0;
      for (int unsigned i = 0; i < NUM_TEST; i++) begin
         if (ptr_q == PW'(i)) begin
            cur_num = tab_num[i];
            cur_ans = tab_ans[i];
         end
      end
      in_range = ptr_q < PW'(NUM_TEST);
      hit      = in_range && (NUM_INST == cur_num);
      skip     = in_range && (NUM_INST > cur_num);
      mism     = skip || (hit && OUTPUT_PORT != cur_ans);
      good     = hit && !mism;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         pass_q  <= '0;
         cyc_q   <= '0;
         got_q   <= '0;
         fidx_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         pass_q  <= pass_d;
         cyc_q   <= cyc_d;
         got_q   <= got_d;
         fidx_q  <= fidx_d;
         err_q   <= err_d;
      end
   end

   // Next state: checkpoint evaluation first, then HALT, then timeout
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      pass_d  = pass_q;
      cyc_d   = cyc_q;
      got_d   = got_q;
      fidx_d  = fidx_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = S_RUN;
               ptr_d   = '0;
               pass_d  = '0;
               cyc_d   = '0;
               got_d   = '0;
               fidx_d  = '0;
               err_d   = 1'b0;
            end
         end
         S_RUN: begin
            if (hit || skip) ptr_d = ptr_q + PW'(1);
            if (good) pass_d = pass_q + PW'(1);
            if (mism && !err_q) begin
               err_d  = 1'b1;
               fidx_d = IDX_W'(ptr_q);
               got_d  = OUTPUT_PORT;
            end
            if (mism && STOP_ON_FAIL != 0) begin
               state_d = S_FAIL;
            end else if (HALT) begin
               if (!err_d && ptr_d == PW'(NUM_TEST)) begin
                  state_d = S_PASS;
               end else begin
                  state_d = S_FAIL;
                  if (!err_d) begin
                     fidx_d = IDX_W'(ptr_d);
                     got_d  = OUTPUT_PORT;
                  end
               end
            end else if (cyc_q == DW'(TIMEOUT - 1)) begin
               state_d = S_TIMEOUT;
            end
            // Counter freezes on the cycle that leaves RUN
            if (state_d == S_RUN && cyc_q != '1) cyc_d = cyc_q + DW'(1);
         end
         default: ;
      endcase
   end

   assign STATUS    = state_q;
   assign FAIL_IDX  = fidx_q;
   assign FAIL_GOT  = got_q;
   assign PASS_CNT  = pass_q;
   assign CYCLE_CNT = cyc_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: directed table, hand sequences and randomized runs
// on a stop-on-fail instance and a continue-on-fail instance sharing stimulus.
module tb_riscv_test_monitor;
   localparam int unsigned NT = 3;
   localparam int unsigned IW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 50;

   logic          CLK = 1'b0;
   logic          RSTn;
   logic          LD_EN;
   logic [IW-1:0] LD_IDX;
   logic [DW-1:0] LD_NUM, LD_ANS;
   logic          START;
   logic [DW-1:0] NUM_INST, OUTPUT_PORT;
   logic          HALT;

   logic [2:0]    st_s, st_c;
   logic [IW-1:0] fi_s, fi_c;
   logic [DW-1:0] fg_s, fg_c, cy_s, cy_c;
   logic [IW:0]   pc_s, pc_c;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   riscv_test_monitor #(.NUM_TEST(NT), .IDX_W(IW), .DW(DW), .TIMEOUT(TO), .STOP_ON_FAIL(1)) dut_s (
      .CLK(CLK), .RSTn(RSTn), .LD_EN(LD_EN), .LD_IDX(LD_IDX), .LD_NUM(LD_NUM), .LD_ANS(LD_ANS),
      .START(START), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
      .STATUS(st_s), .FAIL_IDX(fi_s), .FAIL_GOT(fg_s), .PASS_CNT(pc_s), .CYCLE_CNT(cy_s));

   riscv_test_monitor #(.NUM_TEST(NT), .IDX_W(IW), .DW(DW), .TIMEOUT(TO), .STOP_ON_FAIL(0)) dut_c (
      .CLK(CLK), .RSTn(RSTn), .LD_EN(LD_EN), .LD_IDX(LD_IDX), .LD_NUM(LD_NUM), .LD_ANS(LD_ANS),
      .START(START), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
      .STATUS(st_c), .FAIL_IDX(fi_c), .FAIL_GOT(fg_c), .PASS_CNT(pc_c), .CYCLE_CNT(cy_c));

   // Directed record: stimulus shape, then expected {status,pass,fidx,fgot,cycles} per instance
   typedef struct {
      int bad_n; int bad_val; int jump_from; int jump_to; int halt_n;
      int st_s; int pc_s; int fi_s; int fg_s; int cy_s;
      int st_c; int pc_c; int fi_c; int fg_c; int cy_c;
   } vec_t;

   vec_t        vecs [6];
   int          tn [NT];
   logic [31:0] ta [NT];
   int          sn [64];
   logic [31:0] so [64];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_s(input string tag, input int st, input int pc, input int fi,
                        input logic [31:0] fg, input int cy);
      chk({tag, ".status_s"}, 32'(st_s), 32'(st));
      chk({tag, ".pass_s"},   32'(pc_s), 32'(pc));
      chk({tag, ".fidx_s"},   32'(fi_s), 32'(fi));
      chk({tag, ".fgot_s"},   fg_s, fg);
      chk({tag, ".cyc_s"},    cy_s, 32'(cy));
   endtask

   task automatic chk_c(input string tag, input int st, input int pc, input int fi,
                        input logic [31:0] fg, input int cy);
      chk({tag, ".status_c"}, 32'(st_c), 32'(st));
      chk({tag, ".pass_c"},   32'(pc_c), 32'(pc));
      chk({tag, ".fidx_c"},   32'(fi_c), 32'(fi));
      chk({tag, ".fgot_c"},   fg_c, fg);
      chk({tag, ".cyc_c"},    cy_c, 32'(cy));
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RSTn = 1'b0; LD_EN = 1'b0; LD_IDX = '0; LD_NUM = '0; LD_ANS = '0;
      START = 1'b0; NUM_INST = '0; OUTPUT_PORT = '0; HALT = 1'b0;
      @(negedge CLK);
      RSTn = 1'b1;
   endtask

   task automatic load_table();
      for (int j = 0; j < int'(NT); j++) begin
         @(negedge CLK);
         LD_EN = 1'b1; LD_IDX = IW'(j); LD_NUM = 32'(tn[j]); LD_ANS = ta[j];
      end
      @(negedge CLK);
      LD_EN = 1'b0;
   endtask

   // START pulse, then one sequence element per RUN cycle; HALT on the last if requested
   task automatic run_seq(input int len, input bit halt);
      @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      for (int i = 0; i < len; i++) begin
         NUM_INST = 32'(sn[i]); OUTPUT_PORT = so[i]; HALT = halt && (i == len - 1);
         @(negedge CLK);
      end
      HALT = 1'b0;
   endtask

   // Reference: walk checkpoints in order against the cycle-by-cycle trace
   task automatic model(input int stop, input int len, input bit halt, output int st,
                        output int pc, output int fi, output logic [31:0] fg, output int cy);
      int ptr; bit err; bit done; bit bad;
      ptr = 0; pc = 0; err = 0; fi = 0; fg = 0; cy = 0; st = 1; done = 0;
      for (int i = 0; i < len && !done; i++) begin
         bad = 0;
         if (ptr < int'(NT) && sn[i] >= tn[ptr]) begin
            if (sn[i] == tn[ptr] && so[i] == ta[ptr]) pc++;
            else bad = 1;
            if (bad && !err) begin err = 1; fi = ptr; fg = so[i]; end
            ptr++;
         end
         if (bad && stop != 0) begin
            st = 3; done = 1;
         end else if (halt && i == len - 1) begin
            if (!err && ptr == int'(NT)) st = 2;
            else begin
               st = 3;
               if (!err) begin fi = ptr; fg = so[i]; end
            end
            done = 1;
         end else if (cy == int'(TO) - 1) begin
            st = 4; done = 1;
         end
         if (!done) cy++;
      end
   endtask

   function automatic logic [31:0] good_out(input int n);
      if (n == 4) return 32'heec;
      if (n == 6) return 32'h0;
      if (n == 8) return 32'h1;
      return 32'(n);
   endfunction

   task automatic default_table();
      tn[0] = 4; tn[1] = 6; tn[2] = 8;
      ta[0] = 32'heec; ta[1] = 32'h0; ta[2] = 32'h1;
   endtask

   task automatic build_vec(input vec_t v, output int len);
      int n;
      n = 0; len = 0;
      while (1) begin
         sn[len] = n;
         so[len] = (n == v.bad_n) ? 32'(v.bad_val) : good_out(n);
         len++;
         if (n == v.halt_n || len >= 60) break;
         n = (n == v.jump_from) ? v.jump_to : n + 1;
      end
   endtask

   initial begin
      int len, occ, j0;
      int est, epc, efi, ecy;
      logic [31:0] efg;
      bit halt;

      vecs[0] = '{-1, 0,   -1, -1, 9,  2, 3, 0, 0,   9,  2, 3, 0, 0,   9};
      vecs[1] = '{ 6, 5,   -1, -1, 9,  3, 1, 1, 5,   6,  3, 2, 1, 5,   9};
      vecs[2] = '{-1, 0,    4,  7, 9,  3, 1, 1, 7,   5,  3, 2, 1, 7,   7};
      vecs[3] = '{-1, 0,   -1, -1, 5,  3, 1, 1, 5,   5,  3, 1, 1, 5,   5};
      vecs[4] = '{-1, 0,   -1, -1, 8,  2, 3, 0, 0,   8,  2, 3, 0, 0,   8};
      vecs[5] = '{ 8, 7,   -1, -1, 8,  3, 2, 2, 7,   8,  3, 2, 2, 7,   8};

      RSTn = 1'b0;
      do_reset();
      chk_s("reset", 0, 0, 0, 0, 0);
      chk_c("reset", 0, 0, 0, 0, 0);

      // Directed vectors on the reference table
      default_table();
      for (int v = 0; v < 6; v++) begin
         do_reset();
         load_table();
         build_vec(vecs[v], len);
         run_seq(len, 1'b1);
         chk_s($sformatf("vec%0d", v), vecs[v].st_s, vecs[v].pc_s, vecs[v].fi_s, 32'(vecs[v].fg_s), vecs[v].cy_s);
         chk_c($sformatf("vec%0d", v), vecs[v].st_c, vecs[v].pc_c, vecs[v].fi_c, 32'(vecs[v].fg_c), vecs[v].cy_c);
      end

      // Timeout with NUM_INST stuck below the first checkpoint
      do_reset();
      load_table();
      for (int i = 0; i < 60; i++) begin sn[i] = 0; so[i] = 32'h0; end
      run_seq(60, 1'b0);
      chk_s("timeout", 4, 0, 0, 0, 49);
      chk_c("timeout", 4, 0, 0, 0, 49);
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0;
      chk("start_ignored", 32'(st_s), 32'd4);

      // Reset mid-run; loads during RUN and out-of-range loads must not disturb the table
      do_reset();
      @(negedge CLK); LD_EN = 1'b1; LD_IDX = IW'(3); LD_NUM = 32'd0; LD_ANS = 32'hdead;
      @(negedge CLK); LD_EN = 1'b0;
      run_seq(5, 1'b0);
      chk("midrun.status", 32'(st_s), 32'd1);
      chk("midrun.cyc", cy_s, 32'd5);
      LD_EN = 1'b1; LD_IDX = '0; LD_NUM = 32'd0; LD_ANS = 32'hbad;
      @(negedge CLK); LD_EN = 1'b0;
      RSTn = 1'b0;
      #1;
      chk_s("async_rst", 0, 0, 0, 0, 0);
      chk_c("async_rst", 0, 0, 0, 0, 0);
      @(negedge CLK); RSTn = 1'b1;
      build_vec(vecs[0], len);
      run_seq(len, 1'b1);
      chk_s("table_kept", 2, 3, 0, 0, 9);

      // Randomized tables and traces against the reference
      for (int r = 0; r < 40; r++) begin
         tn[0] = int'($urandom_range(0, 3));
         tn[1] = tn[0] + int'($urandom_range(0, 2));
         tn[2] = tn[1] + int'($urandom_range(0, 2));
         for (int j = 0; j < int'(NT); j++) ta[j] = $urandom & 32'hff;
         len  = int'($urandom_range(4, 20));
         halt = ($urandom_range(0, 7) != 0);
         sn[0] = 0;
         for (int i = 1; i < len; i++) sn[i] = sn[i-1] + int'($urandom_range(0, 2));
         for (int i = 0; i < len; i++) begin
            occ = 0;
            for (int k = 0; k < i; k++) if (sn[k] == sn[i]) occ++;
            j0 = -1;
            for (int j = int'(NT) - 1; j >= 0; j--) if (tn[j] == sn[i]) j0 = j;
            if (j0 >= 0 && j0 + occ < int'(NT) && tn[(j0 + occ) % int'(NT)] == sn[i]
                && $urandom_range(0, 7) != 0)
               so[i] = ta[(j0 + occ) % int'(NT)];
            else
               so[i] = 32'($urandom_range(0, 3));
         end
         do_reset();
         load_table();
         run_seq(len, halt);
         model(1, len, halt, est, epc, efi, efg, ecy);
         chk_s($sformatf("rand%0d", r), est, epc, efi, efg, ecy);
         model(0, len, halt, est, epc, efi, efg, ecy);
         chk_c($sformatf("rand%0d", r), est, epc, efi, efg, ecy);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/riscv_test_monitor.md
RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

Interface
REQ-001 SHALL have parameter NUM_TEST, default 17, number of expected-value checkpoints.
REQ-002 SHALL have parameter IDX_W, default 5, checkpoint index width; NUM_TEST <= 2**IDX_W.
REQ-003 SHALL have parameter DW, default 32, width of NUM_INST, OUTPUT_PORT, answers and counters.
REQ-004 SHALL have parameter TIMEOUT, default 1000000, cycle limit in RUN.
REQ-005 SHALL have parameter STOP_ON_FAIL, default 1; 1 = first mismatch ends run, 0 = record first mismatch and continue.
REQ-006 SHALL have port CLK input 1, single clock, all state on rising edge.
REQ-007 SHALL have port RSTn input 1, asynchronous active-low reset.
REQ-008 SHALL have port LD_EN input 1, writes one checkpoint-table entry.
REQ-009 SHALL have port LD_IDX input IDX_W, table entry written.
REQ-010 SHALL have port LD_NUM input DW, retired-instruction count at which the entry is checked.
REQ-011 SHALL have port LD_ANS input DW, expected OUTPUT_PORT value.
REQ-012 SHALL have port START input 1, one-cycle pulse beginning a run.
REQ-013 SHALL have port NUM_INST input DW, core retired-instruction count.
REQ-014 SHALL have port OUTPUT_PORT input DW, core observable result.
REQ-015 SHALL have port HALT input 1, core halted.
REQ-016 SHALL have port STATUS output 3, one of IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4.
REQ-017 SHALL have port FAIL_IDX output IDX_W, index of first failing checkpoint.
REQ-018 SHALL have port FAIL_GOT output DW, OUTPUT_PORT value captured at first failure.
REQ-019 SHALL have port PASS_CNT output IDX_W+1, checkpoints passed.
REQ-020 SHALL have port CYCLE_CNT output DW, cycles spent in RUN.

Function
REQ-021 Table SHALL hold NUM_TEST (LD_NUM, LD_ANS) pairs, written on a rising edge with LD_EN=1 in IDLE only; LD_EN outside IDLE or with LD_IDX >= NUM_TEST is ignored.
REQ-022 Checkpoints SHALL be evaluated strictly in index order via pointer PTR, cleared to 0 on START.
REQ-023 IDLE -> RUN on START; START in any other state is ignored; PASS/FAIL/TIMEOUT return to IDLE only on reset.
REQ-024 In RUN, on each edge with PTR < NUM_TEST and NUM_INST == LD_NUM[PTR]: OUTPUT_PORT == LD_ANS[PTR] -> PASS_CNT+1; otherwise mismatch; either way PTR+1 next cycle.
REQ-025 In RUN, NUM_INST > LD_NUM[PTR] with no match SHALL be a mismatch (skipped checkpoint), FAIL_GOT = OUTPUT_PORT that cycle.
REQ-026 At most one checkpoint SHALL be evaluated per cycle; equal consecutive LD_NUM values are checked on successive cycles while NUM_INST holds.
REQ-027 On first mismatch FAIL_IDX/FAIL_GOT SHALL latch and never update again in the run; STOP_ON_FAIL=1 -> FAIL next cycle; STOP_ON_FAIL=0 -> stay RUN, sticky error flag set.
REQ-028 HALT=1 in RUN SHALL end the run after that cycle's check: PASS if no error and PTR (after increment) == NUM_TEST, else FAIL; unchecked entries leave FAIL_IDX = PTR, FAIL_GOT = OUTPUT_PORT.
REQ-029 PTR == NUM_TEST without HALT SHALL keep RUN.
REQ-030 CYCLE_CNT SHALL increment every RUN cycle, saturate at all-ones, freeze on leaving RUN; CYCLE_CNT == TIMEOUT-1 with no HALT -> TIMEOUT next cycle.
REQ-031 Checkpoint evaluation SHALL take priority over HALT, HALT over timeout, when coincident.

Reset
REQ-032 RSTn=0 SHALL asynchronously force STATUS=IDLE and PTR, PASS_CNT, CYCLE_CNT, FAIL_IDX, FAIL_GOT, error flag to 0; table contents are not reset; reset mid-run abandons the run.

Verification
REQ-033 NUM_TEST=3, table {(4,0xeec),(6,0),(8,1)}, NUM_INST 0..8 with matching OUTPUT_PORT, HALT at 9 -> STATUS=PASS, PASS_CNT=3.
REQ-034 Same table, OUTPUT_PORT=0x5 at NUM_INST=6, STOP_ON_FAIL=1 -> STATUS=FAIL next cycle, FAIL_IDX=1, FAIL_GOT=0x5, PASS_CNT=1.
REQ-035 Same, STOP_ON_FAIL=0, later entry correct, HALT -> STATUS=FAIL, PASS_CNT=2, FAIL_IDX=1 unchanged.
REQ-036 NUM_INST jumps 4->7 -> mismatch on idx 1 (skip), FAIL_IDX=1.
REQ-037 TIMEOUT=50, no HALT -> STATUS=TIMEOUT after 50 RUN cycles, CYCLE_CNT=49; RSTn pulse mid-run -> IDLE, counters 0, table still matches loaded values.
